// File: rtl/mem_region_mux.sv
// Address decoder and read-data steering for the shared memory port: splits the port
// across 2**IDX_W regions, stalls for 2-cycle regions and records unmapped accesses.
module mem_region_mux #(
    parameter int unsigned IDX_W = 2,
    parameter int unsigned SEL_LO = 17,
    parameter logic [(2**IDX_W)-1:0] REGION_EN = 4'b0011,
    parameter logic [(2**IDX_W)-1:0] REGION_LAT2 = 4'b0000,
    parameter int unsigned BOOT_REGION = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_valid,
    input  logic                          cpu_write,
    input  logic [3:0]                    cpu_wmask,
    input  logic [31:0]                   cpu_addr,
    output logic [31:0]                   cpu_rdata,
    output logic                          cpu_ready,
    output logic                          cpu_fault,
    output logic [(2**IDX_W)-1:0]         reg_write,
    output logic [4*(2**IDX_W)-1:0]       reg_wmask,
    output logic [31:0]                   reg_addr,
    input  logic [32*(2**IDX_W)-1:0]      reg_rdata,
    output logic [31:0]                   fault_addr,
    output logic [7:0]                    fault_cnt
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] q_sel;
    logic             q_unmapped;
    logic             hit;
    logic             accept;
    logic             read_acc;

    assign idx      = cpu_addr[SEL_LO +: IDX_W];
    // Address bits above the index field must be zero, otherwise the access aliases nowhere.
    assign hit      = REGION_EN[idx] && ((cpu_addr >> (SEL_LO + IDX_W)) == 32'd0);
    assign accept   = cpu_valid && cpu_ready;
    assign read_acc = accept && !cpu_write;
    assign reg_addr = cpu_addr;

    always_comb begin
        reg_write = '0;
        reg_wmask = '0;
        if (accept && cpu_write && hit) begin
            reg_write[idx]        = 1'b1;
            reg_wmask[4*idx +: 4] = cpu_wmask;
        end
    end

    assign cpu_rdata = q_unmapped ? '0 : reg_rdata[32*q_sel +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            q_sel      <= IDX_W'(BOOT_REGION);
            q_unmapped <= 1'b0;
            cpu_ready  <= 1'b1;
            cpu_fault  <= 1'b0;
            fault_addr <= '0;
            fault_cnt  <= '0;
        end else begin
            cpu_fault <= accept && !hit;
            if (accept && !hit) begin
                fault_addr <= cpu_addr;
                if (fault_cnt != '1)
                    fault_cnt <= fault_cnt + 8'd1;
            end
            if (read_acc) begin
                q_sel      <= idx;
                q_unmapped <= !hit;
            end
            case (state)
                ST_IDLE: begin
                    if (read_acc && hit && REGION_LAT2[idx]) begin
                        state     <= ST_WAIT;
                        cpu_ready <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    state     <= ST_IDLE;
                    cpu_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_region_mux.sv
// Randomized bench for mem_region_mux: a cycle-counting reference model of the decoder,
// stall timing and fault bookkeeping is compared against the DUT every cycle.
module tb_mem_region_mux;

    localparam logic [3:0] EN   = 4'b0011;
    localparam logic [3:0] LAT2 = 4'b0010;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_valid;
    logic         cpu_write;
    logic [3:0]   cpu_wmask;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_fault;
    logic [3:0]   reg_write;
    logic [15:0]  reg_wmask;
    logic [31:0]  reg_addr;
    logic [127:0] reg_rdata;
    logic [31:0]  fault_addr;
    logic [7:0]   fault_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: ready is derived from a cycle count, not a state machine.
    longint cyc = 0;
    longint busy_until = 0;
    int     m_sel;
    bit     m_unm;
    bit     m_fault;
    logic [31:0] m_faddr;
    int     m_fcnt;

    mem_region_mux #(
        .IDX_W(2),
        .SEL_LO(17),
        .REGION_EN(EN),
        .REGION_LAT2(LAT2),
        .BOOT_REGION(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_wmask(cpu_wmask),
        .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_fault(cpu_fault), .reg_write(reg_write), .reg_wmask(reg_wmask),
        .reg_addr(reg_addr), .reg_rdata(reg_rdata), .fault_addr(fault_addr),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        int r;
        r = int'(a / 32'd131072);
        return (a < 32'd524288) && EN[r];
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 32'd131072) % 32'd4);
    endfunction

    task automatic reset_model();
        busy_until = 0;
        m_sel   = 1;
        m_unm   = 0;
        m_fault = 0;
        m_faddr = 0;
        m_fcnt  = 0;
    endtask

    task automatic step(input logic v, input logic w, input logic [3:0] m, input logic [31:0] a);
        bit          rdy;
        bit          acc;
        bit          h;
        int          ix;
        logic [3:0]  exp_wr;
        logic [15:0] exp_wm;
        logic [31:0] exp_rd;
        @(negedge clk);
        cpu_valid = v;
        cpu_write = w;
        cpu_wmask = m;
        cpu_addr  = a;
        reg_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        rdy = (cyc >= busy_until);
        acc = v && rdy;
        h   = m_hit(a);
        ix  = m_idx(a);
        exp_wr = '0;
        exp_wm = '0;
        if (acc && w && h) begin
            exp_wr = 4'(1 << ix);
            exp_wm = 16'(m) << (4 * ix);
        end
        exp_rd = m_unm ? 32'd0 : reg_rdata[32*m_sel +: 32];
        chk("cpu_ready", cpu_ready, rdy);
        chk("cpu_fault", cpu_fault, m_fault);
        chk("fault_addr", fault_addr, m_faddr);
        chk("fault_cnt", fault_cnt, m_fcnt);
        chk("reg_addr", reg_addr, a);
        chk("reg_write", reg_write, exp_wr);
        chk("reg_wmask", reg_wmask, exp_wm);
        chk("cpu_rdata", cpu_rdata, exp_rd);
        // Advance the model across the coming rising edge.
        m_fault = acc && !h;
        if (acc && !h) begin
            m_faddr = a;
            if (m_fcnt < 255) m_fcnt++;
        end
        if (acc && !w) begin
            m_sel = ix;
            m_unm = !h;
            if (h && LAT2[ix]) busy_until = cyc + 2;
        end
        cyc++;
    endtask

    task automatic rand_addr(output logic [31:0] a);
        case ($urandom_range(0, 5))
            0, 1:    a = {15'd0, 2'd0, 15'($urandom())};
            2, 3:    a = {15'd0, 2'd1, 15'($urandom())};
            4:       a = {15'd0, 2'($urandom_range(2, 3)), 15'($urandom())};
            default: a = $urandom() | 32'h0008_0000;
        endcase
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] lit;
        rst = 1'b1;
        cpu_valid = 0; cpu_write = 0; cpu_wmask = 0; cpu_addr = 0; reg_rdata = '0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hand-computed expectations pinning the model.
        step(0, 0, 4'h0, 32'h0);
        chk("lit_reset_ready", cpu_ready, 1);
        chk("lit_reset_cnt", fault_cnt, 0);
        chk("lit_reset_boot_rdata", cpu_rdata, reg_rdata[63:32]);
        step(1, 1, 4'b0101, 32'h0000_0010);
        chk("lit_wr_strobe", reg_write, 4'b0001);
        chk("lit_wr_mask", reg_wmask, 16'h0005);
        chk("lit_wr_ready", cpu_ready, 1);
        step(1, 0, 4'h0, 32'h0002_0004);
        step(0, 0, 4'h0, 32'h0);
        chk("lit_lat2_stall", cpu_ready, 0);
        step(0, 0, 4'h0, 32'h0);
        chk("lit_lat2_ready", cpu_ready, 1);
        chk("lit_lat2_rdata", cpu_rdata, reg_rdata[63:32]);
        step(1, 0, 4'h0, 32'h0004_0000);
        step(0, 0, 4'h0, 32'h0);
        lit = 32'h0004_0000;
        chk("lit_unmapped_fault", cpu_fault, 1);
        chk("lit_unmapped_addr", fault_addr, lit);
        chk("lit_unmapped_cnt", fault_cnt, 1);
        chk("lit_unmapped_rdata", cpu_rdata, 0);
        chk("lit_unmapped_ready", cpu_ready, 1);
        step(1, 0, 4'h0, 32'h0000_0100);
        step(1, 0, 4'h0, 32'h0002_0000);
        chk("lit_r0_rdata", cpu_rdata, reg_rdata[31:0]);
        chk("lit_b2b_ready", cpu_ready, 1);

        for (int i = 0; i < 300; i++)
            step(1, 1, 4'hF, 32'hC000_0000 | ($urandom() & 32'h3FFF_FFFC));
        step(0, 0, 4'h0, 32'h0);
        chk("lit_sat_cnt", fault_cnt, 255);

        for (int i = 0; i < 3000; i++) begin
            rand_addr(a);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom()), 4'($urandom()), a);
        end

        // Reset while a 2-cycle read is outstanding.
        step(1, 0, 4'h0, 32'h0004_0008);
        step(1, 0, 4'h0, 32'h0002_0008);
        @(negedge clk);
        cpu_valid = 0;
        #1;
        chk("lit_wait_before_rst", cpu_ready, 0);
        chk("lit_cnt_before_rst", fault_cnt != 0, 1);
        rst = 1'b1;
        #1;
        chk("lit_rst_ready", cpu_ready, 1);
        chk("lit_rst_cnt", fault_cnt, 0);
        chk("lit_rst_fault", cpu_fault, 0);
        chk("lit_rst_boot_rdata", cpu_rdata, reg_rdata[63:32]);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rand_addr(a);
            step(1'($urandom()), 1'($urandom()), 4'($urandom()), a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
